// File: rtl/vector_index_sequencer_if.sv
// Control/status bundle between the layer controller (master) and the
// two-level index sequencer (slave).
interface vector_index_sequencer_if #(
  parameter int ELEMENTS = 8,
  parameter int VECTORS  = 4,
  parameter int EW       = $clog2(ELEMENTS),
  parameter int VW       = (VECTORS > 1) ? $clog2(VECTORS) : 1
);
  // start is a request accepted only while busy is low; busy rises the cycle
  // after acceptance and falls in the same cycle the done pulse is high.
  logic          clear;
  logic          start;
  logic          repeat_mode;
  logic          en;
  logic [EW-1:0] element_index;
  logic [VW-1:0] vector_index;
  logic          last_element;
  logic          new_vector;
  logic          done;
  logic          busy;

  modport master (
    output clear, start, repeat_mode, en,
    input  element_index, vector_index, last_element, new_vector, done, busy
  );

  modport slave (
    input  clear, start, repeat_mode, en,
    output element_index, vector_index, last_element, new_vector, done, busy
  );
endinterface

// File: rtl/vector_index_sequencer.sv
// Two-level element/vector index generator with a run/idle FSM, vector and
// layer strobes, and an optional continuous (repeat) mode.
module vector_index_sequencer #(
  parameter int ELEMENTS = 8,
  parameter int VECTORS  = 4,
  parameter int EW       = $clog2(ELEMENTS),
  parameter int VW       = (VECTORS > 1) ? $clog2(VECTORS) : 1
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  vector_index_sequencer_if.slave  bus,
  output logic [0:0]               state_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Explicit terminal values so non-power-of-two sizes never overflow visibly.
  localparam logic [EW-1:0] ELEM_LAST = EW'(ELEMENTS - 1);
  localparam logic [VW-1:0] VEC_LAST  = VW'(VECTORS - 1);

  logic [0:0]    state_q,  state_d;
  logic [EW-1:0] elem_q,   elem_d;
  logic [VW-1:0] vec_q,    vec_d;
  logic          nv_q,     nv_d;
  logic          done_q,   done_d;
  logic          repeat_q, repeat_d;

  always_comb begin
    state_d  = state_q;
    elem_d   = elem_q;
    vec_d    = vec_q;
    repeat_d = repeat_q;
    nv_d     = 1'b0;
    done_d   = 1'b0;

    if (bus.clear) begin
      state_d  = ST_IDLE;
      elem_d   = '0;
      vec_d    = '0;
      repeat_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          elem_d = '0;
          vec_d  = '0;
          if (bus.start) begin
            state_d  = ST_RUN;
            repeat_d = bus.repeat_mode;
          end
        end
        ST_RUN: begin
          if (bus.en) begin
            if (elem_q == ELEM_LAST) begin
              elem_d = '0;
              nv_d   = 1'b1;
              if (vec_q == VEC_LAST) begin
                vec_d = '0;
                if (!repeat_q) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
                end
              end else begin
                vec_d = vec_q + VW'(1);
              end
            end else begin
              elem_d = elem_q + EW'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          elem_d  = '0;
          vec_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      elem_q   <= '0;
      vec_q    <= '0;
      nv_q     <= 1'b0;
      done_q   <= 1'b0;
      repeat_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      elem_q   <= elem_d;
      vec_q    <= vec_d;
      nv_q     <= nv_d;
      done_q   <= done_d;
      repeat_q <= repeat_d;
    end
  end

  assign bus.element_index = elem_q;
  assign bus.vector_index  = vec_q;
  assign bus.new_vector    = nv_q;
  assign bus.done          = done_q;
  assign bus.busy          = (state_q == ST_RUN);
  assign bus.last_element  = (state_q == ST_RUN) && (elem_q == ELEM_LAST);
  assign state_o           = state_q;

endmodule

// File: tb/tb_vector_index_sequencer.sv
// Bench for vector_index_sequencer: a 3x2 instance driven from a vector table
// plus hand sequences, and a 5x1 instance for the non-power-of-two wrap.
module tb_vector_index_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [0:0] state_a, state_b;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  vector_index_sequencer_if #(.ELEMENTS(3), .VECTORS(2)) bus_a ();
  vector_index_sequencer_if #(.ELEMENTS(5), .VECTORS(1)) bus_b ();

  vector_index_sequencer #(.ELEMENTS(3), .VECTORS(2)) dut_a (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus_a),
    .state_o (state_a)
  );

  vector_index_sequencer #(.ELEMENTS(5), .VECTORS(1)) dut_b (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus_b),
    .state_o (state_b)
  );

  typedef struct {
    logic       clr;
    logic       st;
    logic       rpt;
    logic       en;
    logic [1:0] elem;
    logic       vec;
    logic       last;
    logic       nv;
    logic       done;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic c, s, r, e, input logic [1:0] el,
                              input logic v, l, n, d, b);
    vec_t row;
    row.clr = c; row.st = s; row.rpt = r; row.en = e;
    row.elem = el; row.vec = v; row.last = l; row.nv = n; row.done = d; row.busy = b;
    tbl.push_back(row);
  endfunction

  function automatic logic [7:0] pack_exp(input vec_t r);
    return {1'b0, r.elem, r.vec, r.last, r.nv, r.done, r.busy};
  endfunction

  // Scoreboard compare for each instance: pops the oldest expectation.
  task automatic check_a(input string name, input int idx);
    logic [7:0] act, exp;
    act = {1'b0, bus_a.element_index, bus_a.vector_index, bus_a.last_element,
           bus_a.new_vector, bus_a.done, bus_a.busy};
    exp = exp_q.pop_front();
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s[%0d] A: got {e,v,last,nv,done,busy}=%b exp %b", name, idx, act, exp);
    end
  endtask

  task automatic check_b(input string name, input int idx);
    logic [7:0] act, exp;
    act = {bus_b.element_index, bus_b.vector_index, bus_b.last_element,
           bus_b.new_vector, bus_b.done, bus_b.busy};
    exp = exp_q.pop_front();
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s[%0d] B: got {e,v,last,nv,done,busy}=%b exp %b", name, idx, act, exp);
    end
  endtask

  task automatic drive_a(input vec_t r, input string name, input int idx);
    @(negedge clk);
    bus_a.clear = r.clr; bus_a.start = r.st; bus_a.repeat_mode = r.rpt; bus_a.en = r.en;
    exp_q.push_back(pack_exp(r));
    @(posedge clk);
    #1;
    check_a(name, idx);
  endtask

  task automatic drive_b(input logic c, s, r, e, input logic [7:0] exp,
                         input string name, input int idx);
    @(negedge clk);
    bus_b.clear = c; bus_b.start = s; bus_b.repeat_mode = r; bus_b.en = e;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    check_b(name, idx);
  endtask

  initial begin
    vec_t r;
    logic [1:0] el;

    bus_a.clear = 0; bus_a.start = 0; bus_a.repeat_mode = 0; bus_a.en = 0;
    bus_b.clear = 0; bus_b.start = 0; bus_b.repeat_mode = 0; bus_b.en = 0;

    // Single pass with en held high, then en ignored in IDLE.
    add(0,1,0,0, 0,0,0,0,0,1);
    add(0,0,0,1, 1,0,0,0,0,1);
    add(0,0,0,1, 2,0,1,0,0,1);
    add(0,0,0,1, 0,1,0,1,0,1);
    add(0,0,0,1, 1,1,0,0,0,1);
    add(0,0,0,1, 2,1,1,0,0,1);
    add(0,0,0,1, 0,0,0,1,1,0);
    add(0,0,0,1, 0,0,0,0,0,0);
    // Gapped en; start and repeat_mode during RUN have no effect.
    add(0,1,0,0, 0,0,0,0,0,1);
    add(0,0,0,1, 1,0,0,0,0,1);
    add(0,1,0,0, 1,0,0,0,0,1);
    add(0,0,0,1, 2,0,1,0,0,1);
    add(0,0,0,0, 2,0,1,0,0,1);
    add(0,0,0,1, 0,1,0,1,0,1);
    add(0,0,0,0, 0,1,0,0,0,1);
    add(0,0,1,1, 1,1,0,0,0,1);
    add(0,0,0,0, 1,1,0,0,0,1);
    add(0,0,0,1, 2,1,1,0,0,1);
    add(0,0,0,0, 2,1,1,0,0,1);
    add(0,0,0,1, 0,0,0,1,1,0);
    // Start while done is high: next pass begins immediately.
    add(0,1,0,0, 0,0,0,0,0,1);
    add(0,0,0,1, 1,0,0,0,0,1);
    add(0,0,0,1, 2,0,1,0,0,1);
    add(0,0,0,1, 0,1,0,1,0,1);
    add(0,0,0,1, 1,1,0,0,0,1);
    add(0,0,0,1, 2,1,1,0,0,1);
    add(0,0,0,1, 0,0,0,1,1,0);
    add(0,0,0,0, 0,0,0,0,0,0);
    // Repeat mode: 14 ens, no done, busy stays up.
    add(0,1,1,0, 0,0,0,0,0,1);
    for (int k = 1; k <= 14; k++) begin
      el = 2'(k % 3);
      add(0,0,0,1, el, 1'((k / 3) % 2), (el == 2'd2), (el == 2'd0), 0, 1);
    end
    // Clear together with en at the last element: no strobe, back to IDLE.
    add(1,0,0,1, 0,0,0,0,0,0);
    add(0,0,0,1, 0,0,0,0,0,0);

    // Reset state.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(8'h00);
    check_a("reset_state", 0);
    exp_q.push_back(8'h00);
    check_b("reset_state", 0);

    for (int i = 0; i < tbl.size(); i++)
      drive_a(tbl[i], "table", i);

    // Async reset mid-pass at element 1, vector 1.
    r = '{clr:0, st:1, rpt:0, en:0, elem:0, vec:0, last:0, nv:0, done:0, busy:1};
    drive_a(r, "mid_start", 0);
    r.st = 0; r.en = 1; r.elem = 1;
    drive_a(r, "mid_en", 1);
    r.elem = 2; r.last = 1;
    drive_a(r, "mid_en", 2);
    r.elem = 0; r.vec = 1; r.last = 0; r.nv = 1;
    drive_a(r, "mid_en", 3);
    r.elem = 1; r.nv = 0;
    drive_a(r, "mid_en", 4);
    @(negedge clk);
    bus_a.en = 0;
    #1 rst = 1'b1;
    #1;
    exp_q.push_back(8'h00);
    check_a("async_reset", 0);
    #1 rst = 1'b0;
    r = '{clr:0, st:0, rpt:0, en:1, elem:0, vec:0, last:0, nv:0, done:0, busy:0};
    drive_a(r, "post_reset_en", 0);
    drive_a(r, "post_reset_en", 1);
    r.en = 0; r.st = 1; r.busy = 1;
    drive_a(r, "post_reset_start", 0);
    r.st = 0; r.en = 1; r.elem = 1;
    drive_a(r, "post_reset_en", 2);
    r = '{clr:1, st:0, rpt:0, en:0, elem:0, vec:0, last:0, nv:0, done:0, busy:0};
    drive_a(r, "post_reset_clear", 0);

    // Non-power-of-two element count with a single vector.
    drive_b(0,1,0,0, {3'd0, 1'b0, 4'b0001}, "b_start", 0);
    for (int k = 1; k <= 5; k++)
      drive_b(0,0,0,1, {3'(k % 5), 1'b0, (k == 4), (k == 5), (k == 5), (k < 5)},
              "b_en", k);
    drive_b(0,0,0,1, 8'h00, "b_idle_en", 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
